// File: rtl/hms_clock_cfg.sv
// hms_clock_cfg: hour/minute/second clock with RUN and edit states,
// 12/24-hour display, prescaler and optional alarm (HMS_ALARM_EN).
// Ports: clk, rst (sync, high); ss/sel/inc/dec/load/addr/din/mode24 in;
// hrs/min/sec/am_pm_bar/running out; alarm_out/alarm_ack with the macro.
module hms_clock_cfg #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter bit          RST_MODE24    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [2:0] addr,
  input  logic [5:0] din,
  input  logic       mode24,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       am_pm_bar,
`ifdef HMS_ALARM_EN
  output logic       running,
  output logic       alarm_out,
  input  logic       alarm_ack
`else
  output logic       running
`endif
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    RUN, E_AMPM, E_H, E_M, E_S
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode24_q, mode24_d;
  logic [4:0]    hrs_q, hrs_d;
  logic [5:0]    min_o_q, sec_o_q;
  logic          am_pm_q, am_pm_d;
  logic          running_q, running_d;
  logic          tick;
  logic          up, dn;
  logic [4:0]    h12;

`ifdef HMS_ALARM_EN
  logic [4:0]    al_hour_q, al_hour_d;
  logic [5:0]    al_min_q, al_min_d;
  logic          armed_q, armed_d;
  logic          alarm_q, alarm_d;
`endif

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    mode24_d = mode24_q ^ mode24;
    tick     = 1'b0;
    up       = inc & ~dec;
    dn       = dec & ~inc;
    // 12-hour entry: "12" means hour 0 of the current half-day
    h12      = (din == 6'd12) ? 5'd0 : din[4:0];
`ifdef HMS_ALARM_EN
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    armed_d   = armed_q;
    alarm_d   = alarm_q;
`endif

    if (state_q == RUN) begin
      if (ss) begin
        state_d = E_AMPM;
      end else if (presc_q == PMAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (ss) begin
      state_d = RUN;
      presc_d = '0;
    end else if (load) begin
      unique case (addr)
        3'd1: if (din < 6'd60) sec_d = din;
        3'd2: if (din < 6'd60) min_d = din;
        3'd3: begin
          if (mode24_q) begin
            if (din < 6'd24) hour_d = din[4:0];
          end else if (din >= 6'd1 && din <= 6'd12) begin
            hour_d = (hour_q >= 5'd12) ? h12 + 5'd12 : h12;
          end
        end
        3'd4: begin
          if (din[0] && hour_q >= 5'd12)
            hour_d = hour_q - 5'd12;
          else if (!din[0] && hour_q < 5'd12)
            hour_d = hour_q + 5'd12;
        end
`ifdef HMS_ALARM_EN
        3'd5: if (din < 6'd24) al_hour_d = din[4:0];
        3'd6: if (din < 6'd60) al_min_d = din;
        3'd7: armed_d = din[0];
`endif
        default: ;
      endcase
    end else if (sel) begin
      unique case (state_q)
        E_AMPM:  state_d = E_H;
        E_H:     state_d = E_M;
        E_M:     state_d = E_S;
        default: state_d = E_AMPM;
      endcase
    end else if (up || dn) begin
      unique case (state_q)
        E_S: begin
          if (up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          else    sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        end
        E_M: begin
          if (up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else    min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        E_H: begin
          if (up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          else    hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end
        default: begin
          // +12 and -12 mod 24 are the same move
          hour_d = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q + 5'd12;
        end
      endcase
    end

    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

`ifdef HMS_ALARM_EN
    // a new match wins over a coincident acknowledge
    if (armed_q && tick && hour_d == al_hour_q &&
        min_d == al_min_q && sec_d == 6'd0)
      alarm_d = 1'b1;
    else if (alarm_ack)
      alarm_d = 1'b0;
`endif

    if (mode24_d)
      hrs_d = hour_d;
    else if (hour_d == 5'd0)
      hrs_d = 5'd12;
    else if (hour_d > 5'd12)
      hrs_d = hour_d - 5'd12;
    else
      hrs_d = hour_d;
    am_pm_d   = (hour_d < 5'd12);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      presc_q   <= '0;
      mode24_q  <= RST_MODE24;
      hrs_q     <= RST_MODE24 ? 5'd0 : 5'd12;
      min_o_q   <= 6'd0;
      sec_o_q   <= 6'd0;
      am_pm_q   <= 1'b1;
      running_q <= 1'b1;
`ifdef HMS_ALARM_EN
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      armed_q   <= 1'b0;
      alarm_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      mode24_q  <= mode24_d;
      hrs_q     <= hrs_d;
      min_o_q   <= min_d;
      sec_o_q   <= sec_d;
      am_pm_q   <= am_pm_d;
      running_q <= running_d;
`ifdef HMS_ALARM_EN
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      armed_q   <= armed_d;
      alarm_q   <= alarm_d;
`endif
    end
  end

  assign hrs       = hrs_q;
  assign min       = min_o_q;
  assign sec       = sec_o_q;
  assign am_pm_bar = am_pm_q;
  assign running   = running_q;
`ifdef HMS_ALARM_EN
  assign alarm_out = alarm_q;
`endif

endmodule

// File: tb/tb_hms_clock_cfg.sv
// tb_hms_clock_cfg: vector table, directed sequences and a random run
// against a seconds-of-day reference model.
module tb_hms_clock_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ss, sel, inc, dec, load, mode24;
  logic [2:0] addr;
  logic [5:0] din;
  logic [4:0] hrs1, hrs4;
  logic [5:0] min1, min4, sec1, sec4;
  logic ap1, ap4, run1, run4;
`ifdef HMS_ALARM_EN
  logic alarm_ack, al1, al4;
`endif

  int total = 0;
  int bad = 0;

  hms_clock_cfg #(.TICKS_PER_SEC(1), .RST_MODE24(1'b0)) d1 (
    .clk(clk), .rst(rst), .ss(ss), .sel(sel), .inc(inc), .dec(dec),
    .load(load), .addr(addr), .din(din), .mode24(mode24),
    .hrs(hrs1), .min(min1), .sec(sec1), .am_pm_bar(ap1),
`ifdef HMS_ALARM_EN
    .running(run1), .alarm_out(al1), .alarm_ack(alarm_ack)
`else
    .running(run1)
`endif
  );

  hms_clock_cfg #(.TICKS_PER_SEC(4), .RST_MODE24(1'b0)) d4 (
    .clk(clk), .rst(rst), .ss(ss), .sel(sel), .inc(inc), .dec(dec),
    .load(load), .addr(addr), .din(din), .mode24(mode24),
    .hrs(hrs4), .min(min4), .sec(sec4), .am_pm_bar(ap4),
`ifdef HMS_ALARM_EN
    .running(run4), .alarm_out(al4), .alarm_ack(alarm_ack)
`else
    .running(run4)
`endif
  );

  typedef struct {
    int r, s, sl, i, d, l, a, dn, m;
    int h, mi, se, ap, run;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int r, int s, int sl, int i, int d,
                              int l, int a, int dn, int m,
                              int h, int mi, int se, int ap, int run);
    vec_t v;
    v.r = r; v.s = s; v.sl = sl; v.i = i; v.d = d;
    v.l = l; v.a = a; v.dn = dn; v.m = m;
    v.h = h; v.mi = mi; v.se = se; v.ap = ap; v.run = run;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic drive(input int r, input int s, input int sl,
                       input int i, input int d, input int l,
                       input int a, input int dn, input int m);
    rst = r[0]; ss = s[0]; sel = sl[0]; inc = i[0]; dec = d[0];
    load = l[0]; addr = a[2:0]; din = dn[5:0]; mode24 = m[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0,0,0,0,0,0,0,0,0);
  endtask

  // reference model: time as seconds of day, state as an index
  int t_m, st_m, m24_m;

  function automatic int disp_h(int h, int m24);
    if (m24 != 0) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic model(input int r, input int s, input int sl,
                       input int i, input int d, input int l,
                       input int a, input int dn, input int m);
    int h, mi, se;
    h = t_m / 3600; mi = (t_m / 60) % 60; se = t_m % 60;
    if (r != 0) begin
      t_m = 0; st_m = 0; m24_m = 0;
      return;
    end
    if (st_m == 0) begin
      if (s != 0) st_m = 1;
      else t_m = (t_m + 1) % 86400;
    end else if (s != 0) begin
      st_m = 0;
    end else if (l != 0) begin
      if (a == 1 && dn < 60) se = dn;
      if (a == 2 && dn < 60) mi = dn;
      if (a == 3 && m24_m != 0 && dn < 24) h = dn;
      if (a == 3 && m24_m == 0 && dn >= 1 && dn <= 12)
        h = (dn % 12) + ((h >= 12) ? 12 : 0);
      if (a == 4) h = (dn % 2 == 1) ? h % 12 : h % 12 + 12;
      t_m = h * 3600 + mi * 60 + se;
    end else if (sl != 0) begin
      st_m = (st_m == 4) ? 1 : st_m + 1;
    end else if (i != d) begin
      int dir;
      dir = (i != 0) ? 1 : -1;
      case (st_m)
        1: h = (h + 12) % 24;
        2: h = (h + dir + 24) % 24;
        3: mi = (mi + dir + 60) % 60;
        default: se = (se + dir + 60) % 60;
      endcase
      t_m = h * 3600 + mi * 60 + se;
    end
    if (m != 0) m24_m = 1 - m24_m;
  endtask

  initial begin
    rst = 1'b1; ss = 0; sel = 0; inc = 0; dec = 0; load = 0;
    addr = 0; din = 0; mode24 = 0;
`ifdef HMS_ALARM_EN
    alarm_ack = 0;
`endif

    //         r s sl i d l a dn m   h mi se ap run
    tv.push_back(mk(1,0,0,0,0,0,0, 0,0, 12, 0, 0,1,1));
    tv.push_back(mk(0,1,0,0,0,0,0, 0,0, 12, 0, 0,1,0));
    tv.push_back(mk(0,0,0,0,0,1,3,11,0, 11, 0, 0,1,0));
    tv.push_back(mk(0,0,0,0,0,1,2,59,0, 11,59, 0,1,0));
    tv.push_back(mk(0,0,0,0,0,1,1,55,0, 11,59,55,1,0));
    tv.push_back(mk(0,1,0,0,0,0,0, 0,0, 11,59,55,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 11,59,56,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 11,59,57,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 11,59,58,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 11,59,59,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 12, 0, 0,0,1));
    tv.push_back(mk(0,0,0,0,0,1,1, 5,0, 12, 0, 1,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,1, 12, 0, 2,0,1));
    tv.push_back(mk(0,1,0,0,0,0,0, 0,0, 12, 0, 2,0,0));
    tv.push_back(mk(0,0,0,1,0,0,0, 0,0,  0, 0, 2,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0,  0, 0, 2,1,0));
    tv.push_back(mk(0,0,0,0,1,0,0, 0,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,0,1,1,0,0, 0,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,0,0,0,1,2,60,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,0,0,0,1,0, 5,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,0,0,0,1,3,24,0, 23, 0, 2,0,0));
    tv.push_back(mk(0,0,0,0,0,1,3, 5,0,  5, 0, 2,1,0));
    tv.push_back(mk(0,0,0,0,0,1,4, 0,0, 17, 0, 2,0,0));
    tv.push_back(mk(0,0,1,0,0,1,1,30,0, 17, 0,30,0,0));
    tv.push_back(mk(0,0,0,1,0,0,0, 0,0, 17, 1,30,0,0));
    tv.push_back(mk(0,1,0,0,0,1,1,10,0, 17, 1,30,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0, 0,0, 17, 1,31,0,1));
    tv.push_back(mk(1,1,0,0,0,0,0, 0,0, 12, 0, 0,1,1));
    tv.push_back(mk(0,1,0,0,0,0,0, 0,0, 12, 0, 0,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0, 12, 0, 0,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0, 12, 0, 0,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0, 12, 0, 0,1,0));
    tv.push_back(mk(0,0,0,0,1,0,0, 0,0, 12, 0,59,1,0));
    tv.push_back(mk(0,0,1,0,0,0,0, 0,0, 12, 0,59,1,0));
    tv.push_back(mk(0,0,0,0,1,0,0, 0,0, 12, 0,59,0,0));
    tv.push_back(mk(0,0,0,0,0,1,3, 3,0,  3, 0,59,0,0));
    tv.push_back(mk(0,0,0,0,0,1,4, 1,0,  3, 0,59,1,0));

    for (int n = 0; n < tv.size(); n++) begin
      vec_t v;
      v = tv[n];
      drive(v.r, v.s, v.sl, v.i, v.d, v.l, v.a, v.dn, v.m);
      chk($sformatf("vec%0d_hrs", n), hrs1, v.h);
      chk($sformatf("vec%0d_min", n), min1, v.mi);
      chk($sformatf("vec%0d_sec", n), sec1, v.se);
      chk($sformatf("vec%0d_ampm", n), ap1, v.ap);
      chk($sformatf("vec%0d_run", n), run1, v.run);
    end

    // one minute of running from reset
    drive(1,0,0,0,0,0,0,0,0);
    chk("rst_hrs12", hrs1, 12);
    chk("rst_ampm", ap1, 1);
    chk("rst_hrs12_t4", hrs4, 12);
    idle(60);
    chk("minute_min", min1, 1);
    chk("minute_sec", sec1, 0);

    // 23:59:55 then 24-hour mode and rollover to midnight
    drive(1,0,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,1,3,11,0);
    drive(0,0,0,0,0,1,4,0,0);
    drive(0,0,0,0,0,1,2,59,0);
    drive(0,0,0,0,0,1,1,55,0);
    drive(0,0,0,0,0,0,0,0,1);
    chk("m24_hrs23", hrs1, 23);
    chk("m24_ampm_pm", ap1, 0);
    drive(0,1,0,0,0,0,0,0,0);
    idle(5);
    chk("midnight_hrs", hrs1, 0);
    chk("midnight_min", min1, 0);
    chk("midnight_sec", sec1, 0);
    chk("midnight_ampm", ap1, 1);

    // minute edit wraps without carry
    drive(1,0,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    drive(0,0,1,0,0,0,0,0,0);
    drive(0,0,1,0,0,0,0,0,0);
    drive(0,0,0,0,0,1,2,58,0);
    for (int k = 0; k < 5; k++) drive(0,0,0,1,0,0,0,0,0);
    chk("edit_min", min1, 3);
    chk("edit_hrs", hrs1, 12);
    drive(0,0,0,1,1,0,0,0,0);
    chk("incdec_min", min1, 3);

    // prescaler restart on RUN re-entry, load ignored in RUN
    drive(1,0,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    chk("t4_running", run4, 1);
    chk("t4_sec0", sec4, 0);
    drive(0,0,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,1,1,30,0);
    drive(0,0,0,0,0,0,0,0,0);
    chk("t4_sec_before", sec4, 0);
    drive(0,0,0,0,0,0,0,0,0);
    chk("t4_sec_tick", sec4, 1);

`ifdef HMS_ALARM_EN
    drive(1,0,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,1,5,0,0);
    drive(0,0,0,0,0,1,6,1,0);
    drive(0,0,0,0,0,1,7,1,0);
    drive(0,1,0,0,0,0,0,0,0);
    idle(59);
    chk("alarm_early", al1, 0);
    idle(1);
    chk("alarm_rise", al1, 1);
    chk("alarm_min", min1, 1);
    idle(1);
    chk("alarm_hold", al1, 1);
    alarm_ack = 1'b1;
    idle(1);
    alarm_ack = 1'b0;
    chk("alarm_ack", al1, 0);
`endif

    // random run against the model
    drive(1,0,0,0,0,0,0,0,0);
    t_m = 0; st_m = 0; m24_m = 0;
    for (int n = 0; n < 3000; n++) begin
      int r, s, sl, i, d, l, a, dn, m;
      int h;
      r  = ($urandom_range(0,199) == 0) ? 1 : 0;
      s  = ($urandom_range(0,19) == 0) ? 1 : 0;
      sl = ($urandom_range(0,5) == 0) ? 1 : 0;
      i  = ($urandom_range(0,3) == 0) ? 1 : 0;
      d  = ($urandom_range(0,3) == 0) ? 1 : 0;
      l  = ($urandom_range(0,4) == 0) ? 1 : 0;
      a  = $urandom_range(0,7);
      dn = $urandom_range(0,63);
      m  = ($urandom_range(0,29) == 0) ? 1 : 0;
      drive(r, s, sl, i, d, l, a, dn, m);
      model(r, s, sl, i, d, l, a, dn, m);
      h = t_m / 3600;
      total++;
      if (hrs1 != disp_h(h, m24_m) || min1 != (t_m / 60) % 60 ||
          sec1 != t_m % 60 || ap1 != (h < 12) ||
          run1 != (st_m == 0)) begin
        bad++;
        $display("FAIL rand%0d got=%0d:%0d:%0d ap=%0d run=%0d want=%0d:%0d:%0d ap=%0d run=%0d",
                 n, hrs1, min1, sec1, ap1, run1, disp_h(h, m24_m),
                 (t_m / 60) % 60, t_m % 60, (h < 12), (st_m == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
